// File: rtl/comb_sweep_chk.sv
// Exhaustive sweep checker: steps VEC through all 2^N values and counts Y_REF/Y_DUT mismatches.
// Optional COMB_SWEEP_STOP_EN: end the sweep at the first mismatch, holding VEC at the failing value.
module comb_sweep_chk #(
    parameter int N     = 4,
    parameter int DWELL = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    output logic [N-1:0] VEC,
    input  logic         Y_REF,
    input  logic         Y_DUT,
    output logic         BUSY,
    output logic         DONE,
    output logic [N:0]   ERR_CNT,
    output logic         ERR_FLAG,
    output logic [N-1:0] FIRST_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
    localparam logic [N-1:0] VEC_LAST   = {N{1'b1}};
    localparam logic [N:0]   ERR_MAX    = {(N+1){1'b1}};

    state_t       state_r, state_nxt_s;
    logic [7:0]   dwell_r, dwell_nxt_s;
    logic [N-1:0] vec_r, vec_nxt_s;
    logic [N-1:0] first_err_r, first_err_nxt_s;
    logic [N:0]   err_cnt_r, err_cnt_nxt_s;
    logic         err_flag_r, err_flag_nxt_s;
    logic         busy_r, busy_nxt_s;
    logic         done_r, done_nxt_s;
    logic         compare_s, mismatch_s, stop_s, sweep_end_s;

    // Only the final dwell cycle of a vector is a compare; earlier cycles let the logic settle.
    assign compare_s   = (state_r == S_RUN) && (dwell_r == DWELL_LAST);
    assign mismatch_s  = compare_s && (Y_REF != Y_DUT);
`ifdef COMB_SWEEP_STOP_EN
    assign stop_s      = mismatch_s;
`else
    assign stop_s      = 1'b0;
`endif
    assign sweep_end_s = compare_s && ((vec_r == VEC_LAST) || stop_s);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; START is only honoured outside RUN
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_FIN: begin
                if (START) state_nxt_s = S_RUN;
                else       state_nxt_s = state_r;
            end
            S_RUN: begin
                if (sweep_end_s) state_nxt_s = S_FIN;
                else             state_nxt_s = S_RUN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath next values: vector stepping, dwell counting and error bookkeeping
    always_comb begin
        dwell_nxt_s     = dwell_r;
        vec_nxt_s       = vec_r;
        first_err_nxt_s = first_err_r;
        err_cnt_nxt_s   = err_cnt_r;
        err_flag_nxt_s  = err_flag_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = done_r;
        case (state_r)
            S_IDLE, S_FIN: begin
                if (START) begin
                    dwell_nxt_s     = 8'd0;
                    vec_nxt_s       = {N{1'b0}};
                    first_err_nxt_s = {N{1'b0}};
                    err_cnt_nxt_s   = {(N+1){1'b0}};
                    err_flag_nxt_s  = 1'b0;
                    busy_nxt_s      = 1'b1;
                    done_nxt_s      = 1'b0;
                end else begin
                    busy_nxt_s      = 1'b0;
                end
            end
            S_RUN: begin
                if (compare_s) begin
                    // The mismatch of the last vector is booked in the same edge that ends the sweep.
                    if (mismatch_s) begin
                        if (err_cnt_r != ERR_MAX) err_cnt_nxt_s = err_cnt_r + {{N{1'b0}}, 1'b1};
                        else                      err_cnt_nxt_s = err_cnt_r;
                        if (!err_flag_r) begin
                            err_flag_nxt_s  = 1'b1;
                            first_err_nxt_s = vec_r;
                        end else begin
                            first_err_nxt_s = first_err_r;
                        end
                    end else begin
                        err_cnt_nxt_s = err_cnt_r;
                    end
                    dwell_nxt_s = 8'd0;
                    if (sweep_end_s) begin
                        busy_nxt_s = 1'b0;
                        done_nxt_s = 1'b1;
                        if (stop_s) vec_nxt_s = vec_r;
                        else        vec_nxt_s = {N{1'b0}};
                    end else begin
                        vec_nxt_s = vec_r + {{(N-1){1'b0}}, 1'b1};
                    end
                end else begin
                    dwell_nxt_s = dwell_r + 8'd1;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            dwell_r     <= 8'd0;
            vec_r       <= {N{1'b0}};
            first_err_r <= {N{1'b0}};
            err_cnt_r   <= {(N+1){1'b0}};
            err_flag_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            dwell_r     <= dwell_nxt_s;
            vec_r       <= vec_nxt_s;
            first_err_r <= first_err_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            err_flag_r  <= err_flag_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign VEC       = vec_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign ERR_CNT   = err_cnt_r;
    assign ERR_FLAG  = err_flag_r;
    assign FIRST_ERR = first_err_r;

endmodule

// File: tb/tb_comb_sweep_chk.sv
// Randomised bench for comb_sweep_chk: a DWELL=1 and a DWELL=3 instance swept side by side
// against a reference model built from the list of faulty vectors.
module tb_comb_sweep_chk;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  vec1, vec3, first1, first3;
    logic [4:0]  cnt1, cnt3;
    logic        busy1, busy3, done1, done3, flag1, flag3;
    logic        y_ref1, y_dut1, y_ref3, y_dut3;
    logic [15:0] bad_r;
    logic        noise3;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [3:0] v);
        return (v[0] & v[1]) | (v[2] & ~v[3]);
    endfunction

    assign y_ref1 = golden(vec1);
    assign y_dut1 = y_ref1 ^ bad_r[vec1];
    assign y_ref3 = golden(vec3);
    assign y_dut3 = y_ref3 ^ (bad_r[vec3] | noise3);

    comb_sweep_chk #(.N(4), .DWELL(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start), .VEC(vec1), .Y_REF(y_ref1), .Y_DUT(y_dut1),
        .BUSY(busy1), .DONE(done1), .ERR_CNT(cnt1), .ERR_FLAG(flag1), .FIRST_ERR(first1)
    );

    comb_sweep_chk #(.N(4), .DWELL(3)) u_dut3 (
        .CLK(clk), .RST(rst), .START(start), .VEC(vec3), .Y_REF(y_ref3), .Y_DUT(y_dut3),
        .BUSY(busy3), .DONE(done3), .ERR_CNT(cnt3), .ERR_FLAG(flag3), .FIRST_ERR(first3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outcome of one sweep given the set of vectors whose compare disagrees.
    task automatic model(input logic [15:0] bad, input int d, output int len, output int cnt,
                         output int flag, output int first, output int fvec);
        cnt = 0; flag = 0; first = 0; fvec = 0; len = 16 * d;
        for (int v = 0; v < 16; v++) begin
            if (bad[v]) begin
                cnt++;
                if (flag == 0) begin
                    flag  = 1;
                    first = v;
                end
            end
        end
`ifdef COMB_SWEEP_STOP_EN
        if (flag != 0) begin
            cnt  = 1;
            len  = (first + 1) * d;
            fvec = first;
        end
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_vec1"},  32'(vec1),  32'd0);
        check_val({tag, "_busy1"}, 32'(busy1), 32'd0);
        check_val({tag, "_done1"}, 32'(done1), 32'd0);
        check_val({tag, "_cnt1"},  32'(cnt1),  32'd0);
        check_val({tag, "_flag1"}, 32'(flag1), 32'd0);
        check_val({tag, "_frst1"}, 32'(first1), 32'd0);
        check_val({tag, "_vec3"},  32'(vec3),  32'd0);
        check_val({tag, "_busy3"}, 32'(busy3), 32'd0);
        check_val({tag, "_done3"}, 32'(done3), 32'd0);
        check_val({tag, "_cnt3"},  32'(cnt3),  32'd0);
    endtask

    task automatic run_sweep(input logic [15:0] bad, input logic noisy, input logic mid_start);
        int len1, e_cnt1, e_flag1, e_first1, e_vec1;
        int len3, e_cnt3, e_flag3, e_first3, e_vec3;
        int span;
        model(bad, 1, len1, e_cnt1, e_flag1, e_first1, e_vec1);
        model(bad, 3, len3, e_cnt3, e_flag3, e_first3, e_vec3);
        span = (len3 > len1 ? len3 : len1) + 2;
        bad_r  = bad;
        noise3 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < span; c++) begin
            noise3 = noisy && ((c % 3) != 2);
            start  = mid_start && (c == 3);
            check_val("busy1", 32'(busy1), 32'(c < len1));
            check_val("done1", 32'(done1), 32'(c >= len1));
            if (c < len1) check_val("vec1", 32'(vec1), 32'(c));
            check_val("busy3", 32'(busy3), 32'(c < len3));
            check_val("done3", 32'(done3), 32'(c >= len3));
            if (c < len3) check_val("vec3", 32'(vec3), 32'(c / 3));
            @(negedge clk);
        end
        start  = 1'b0;
        noise3 = 1'b0;
        check_val("cnt1",   32'(cnt1),   32'(e_cnt1));
        check_val("flag1",  32'(flag1),  32'(e_flag1));
        check_val("first1", 32'(first1), 32'(e_first1));
        check_val("fvec1",  32'(vec1),   32'(e_vec1));
        check_val("cnt3",   32'(cnt3),   32'(e_cnt3));
        check_val("flag3",  32'(flag3),  32'(e_flag3));
        check_val("first3", 32'(first3), 32'(e_first3));
        check_val("fvec3",  32'(vec3),   32'(e_vec3));
    endtask

    initial begin
        bit reached;
        rst    = 1'b1;
        start  = 1'b1;
        bad_r  = 16'h0000;
        noise3 = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("rst");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle_zero("idle");

        run_sweep(16'h0000, 1'b0, 1'b1);
        run_sweep(16'h1020, 1'b0, 1'b0);
        run_sweep(16'h0000, 1'b1, 1'b0);
        run_sweep(16'hFFFF, 1'b0, 1'b0);

        // Abort mid-sweep with RST (START held too, which reset must override).
        bad_r = 16'h00FF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (vec1 == 4'd7) reached = 1'b1;
            else @(negedge clk);
        end
        check_val("reach_vec7", 32'(reached), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_idle_zero("abort");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle_zero("post_abort");
        run_sweep(16'h0000, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_sweep(16'($urandom), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_sweep_chk.md
COMB_SWEEP_CHK -- requirements
Module: comb_sweep_chk

Interface
REQ-001 SHALL have parameter N, default 4: number of combinational inputs swept, legal range 1..16.
REQ-002 SHALL have parameter DWELL, default 1: cycles each vector is held, legal range 1..255.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port START, input, 1: begin a sweep; sampled only in IDLE or FIN.
REQ-006 SHALL have port VEC, output, N: input vector driven to both functions under test.
REQ-007 SHALL have port Y_REF, input, 1: reference function output for the current VEC.
REQ-008 SHALL have port Y_DUT, input, 1: implementation output for the current VEC.
REQ-009 SHALL have port BUSY, output, 1: high while a sweep is running.
REQ-010 SHALL have port DONE, output, 1: high from sweep completion until the next START or RST.
REQ-011 SHALL have port ERR_CNT, output, N+1: number of mismatching vectors in the current or last sweep.
REQ-012 SHALL have port ERR_FLAG, output, 1: high once any mismatch has occurred in the current or last sweep.
REQ-013 SHALL have port FIRST_ERR, output, N: VEC value of the first mismatch; 0 when ERR_FLAG is low.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and FIN, with RST forcing IDLE.
REQ-015 SHALL move IDLE->RUN or FIN->RUN on the edge where START=1; on that edge it SHALL set VEC=0, clear ERR_CNT, ERR_FLAG and FIRST_ERR, clear the dwell counter, and drop DONE.
REQ-016 SHALL ignore START while in RUN, with no restart and no effect on counters.
REQ-017 SHALL hold each VEC value for exactly DWELL cycles in RUN, then increment VEC by 1.
REQ-018 SHALL compare Y_REF against Y_DUT only in the last dwell cycle of each vector; earlier dwell cycles are settling time and SHALL be ignored.
REQ-019 SHALL, on a mismatch, increment ERR_CNT by 1; ERR_CNT can reach 2^N and SHALL never wrap.
REQ-020 SHALL, on the first mismatch of a sweep, set ERR_FLAG=1 and latch FIRST_ERR=VEC; later mismatches SHALL leave FIRST_ERR unchanged.
REQ-021 SHALL, after the compare of VEC=2^N-1, go RUN->FIN, set VEC=0, BUSY=0 and DONE=1, with no wrap into a second pass.
REQ-022 SHALL keep BUSY=1 in RUN only, so that a full sweep lasts exactly 2^N*DWELL cycles of BUSY.
REQ-023 SHALL count a compare cycle that coincides with a mismatch before the FIN transition, so the last vector is always checked.

Reset
REQ-024 SHALL, when RST=1 at an edge and regardless of state, produce VEC=0, BUSY=0, DONE=0, ERR_CNT=0, ERR_FLAG=0, FIRST_ERR=0 and state IDLE.
REQ-025 SHALL abort a sweep on RST mid-sweep without reaching FIN and discard all results.
REQ-026 SHALL give RST priority over START when both are high in the same cycle.

Configuration
REQ-027 SHALL, with macro COMB_SWEEP_STOP_EN defined, go RUN->FIN on the first mismatch's compare edge, with VEC held at the failing value, DONE=1, ERR_CNT=1 and FIRST_ERR=VEC.
REQ-028 SHALL, without COMB_SWEEP_STOP_EN, always sweep all 2^N vectors and count every mismatch (REQ-021).

Verification
REQ-029 SHALL cover: N=4, DWELL=1, Y_DUT=Y_REF=A&B|C&~D, START pulse at edge k -> VEC steps 0..15 over k+1..k+16, DONE=1 at k+17, ERR_CNT=0, ERR_FLAG=0.
REQ-030 SHALL cover: N=4, DWELL=1, Y_DUT differs only at VEC=5 and 12 -> ERR_CNT=2, ERR_FLAG=1, FIRST_ERR=5; with COMB_SWEEP_STOP_EN -> FIN after the VEC=5 compare, ERR_CNT=1.
REQ-031 SHALL cover: N=4, DWELL=3, Y_DUT wrong for the first 2 cycles of each vector and correct on the 3rd -> ERR_CNT=0, BUSY high for 48 cycles.
REQ-032 SHALL cover: Y_DUT=~Y_REF for all vectors, N=4 -> ERR_CNT=16 with no wrap, FIRST_ERR=0.
REQ-033 SHALL cover: RST asserted during VEC=7, then START -> outputs at reset values, then a fresh sweep from VEC=0 with ERR_CNT=0.
REQ-034 SHALL cover: START pulsed at VEC=3 in RUN and again in FIN -> the first pulse is ignored; the second restarts, clears DONE and clears the counters.
